// File: rtl/hw0_ctrl_pkg.sv
// Shared definitions for the HW0 exhaustive sequencer: FSM encoding, vector and counter widths.
// No logic of its own; the helpers below are pure functions.
package hw0_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;
  localparam int CNT_W   = 5;

  typedef logic [VEC_W-1:0] vec_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam vec_t LAST_VEC = 4'hF;

  function automatic logic is_last(input vec_t v);
    return v == LAST_VEC;
  endfunction

  // Run exit is decided by an explicit compare, so the increment never needs to wrap.
  function automatic vec_t next_vec(input vec_t v);
    return v + vec_t'(1);
  endfunction

endpackage

// File: rtl/hw0_settle_timer.sv
// Purpose: loadable down-counter that times the settle window after a new vector is driven.
// Latency: expire is high in the SETTLE_CYCLES-th cycle after the load cycle.
// Backpressure: none; load always wins and restarts the window.
module hw0_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int W = $clog2(SETTLE_CYCLES + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= W'(SETTLE_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // Counter sits at SETTLE_CYCLES in the first settle cycle, so 1 marks the last one.
  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/hw0_exhaustive_sequencer.sv
// Purpose: steps the HW0 unit pair through all 16 vectors, compares P_a/P_b, reports count and first failure.
// Latency: SETTLE_CYCLES+2 cycles per vector; HW0_STOP_ON_FAIL_EN ends the run at the first mismatch.
// Backpressure: Start is ignored while Busy and never queued; Start held in DONE restarts at once.
module hw0_exhaustive_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  output logic       H1,
  output logic       H2,
  output logic       B1,
  output logic       B2,
  input  logic       P_a,
  input  logic       P_b,
  output logic       Busy,
  output logic       Done,
  output logic       Pass,
  output logic [4:0] MismatchCnt,
  output logic       FailValid,
  output logic [3:0] FirstFailVec
);

  import hw0_ctrl_pkg::*;

  state_t state_q, state_d;
  vec_t   vec_q, vec_d;
  cnt_t   cnt_q, cnt_d;
  logic   fv_q, fv_d;
  vec_t   ffv_q, ffv_d;
  logic   tmr_load;
  logic   tmr_expire;
  logic   mismatch;

  hw0_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk   (Clk),
    .rst   (Rst),
    .load  (tmr_load),
    .expire(tmr_expire)
  );

  assign mismatch = P_a ^ P_b;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      ffv_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      ffv_q   <= ffv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    fv_d     = fv_q;
    ffv_d    = ffv_q;
    tmr_load = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d = ST_DRIVE;
          vec_d   = '0;
          cnt_d   = '0;
          fv_d    = 1'b0;
          ffv_d   = '0;
        end
      end
      ST_DRIVE: begin
        tmr_load = 1'b1;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr_expire) begin
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (mismatch) begin
          cnt_d = cnt_q + cnt_t'(1);
          if (!fv_q) begin
            fv_d  = 1'b1;
            ffv_d = vec_q;
          end
        end
`ifdef HW0_STOP_ON_FAIL_EN
        if (mismatch) begin
          state_d = ST_DONE;
        end else if (is_last(vec_q)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRIVE;
          vec_d   = next_vec(vec_q);
        end
`else
        if (is_last(vec_q)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRIVE;
          vec_d   = next_vec(vec_q);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The drive lines are the vector register itself: they move only when DRIVE is entered.
  assign {H1, H2, B1, B2} = vec_q;

  assign Busy         = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_COMPARE);
  assign Done         = (state_q == ST_DONE);
  assign Pass         = Done && (cnt_q == '0);
  assign MismatchCnt  = cnt_q;
  assign FailValid    = fv_q;
  assign FirstFailVec = ffv_q;

endmodule

// File: tb/tb_hw0_exhaustive_sequencer.sv
// Bench for hw0_exhaustive_sequencer: random unit truth tables and fault masks against a reference model.
module tb_hw0_exhaustive_sequencer;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Start;
  logic       H1, H2, B1, B2;
  logic       P_a = 1'b0;
  logic       P_b = 1'b0;
  logic       Busy, Done, Pass, FailValid;
  logic [4:0] MismatchCnt;
  logic [3:0] FirstFailVec;

  hw0_exhaustive_sequencer #(.SETTLE_CYCLES(2)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Start       (Start),
    .H1          (H1),
    .H2          (H2),
    .B1          (B1),
    .B2          (B2),
    .P_a         (P_a),
    .P_b         (P_b),
    .Busy        (Busy),
    .Done        (Done),
    .Pass        (Pass),
    .MismatchCnt (MismatchCnt),
    .FailValid   (FailValid),
    .FirstFailVec(FirstFailVec)
  );

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int          passes = 0;
  int          total  = 0;
  int unsigned t0     = 0;
  bit          running = 1'b0;
  bit          glitch  = 1'b0;
  logic [15:0] pa_tt   = '0;
  logic [15:0] fmask   = '0;
  wire  [3:0]  hv      = {H1, H2, B1, B2};

`ifdef HW0_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  // Unit pair: P_a from a truth table, P_b differs wherever the fault mask is set.
  // In glitch mode both outputs are noise except in the cycle before the compare edge.
  always @(posedge Clk) begin
    #1;
    if (running && glitch && ((cyc - t0) % 4 != 0)) begin
      P_a = 1'($urandom);
      P_b = 1'($urandom);
    end else begin
      P_a = pa_tt[hv];
      P_b = pa_tt[hv] ^ fmask[hv];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_outs"}, {17'd0, hv, Busy, Done, Pass, MismatchCnt, FailValid, FirstFailVec}, 32'd0);
  endtask

  function automatic int popcount16(input logic [15:0] m);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m[i]);
    return n;
  endfunction

  function automatic int first_set(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return 0;
  endfunction

  // One full run: Start goes high after reference edge 0, DUT accepts it on edge 1.
  task automatic run(input logic [15:0] tt, input logic [15:0] m, input bit gl,
                     input bit repulse, input string tag);
    int   done_rel = -1;
    int   rel;
    int   seq_bad = 0;
    int   exp_cnt, exp_first, exp_done;
    logic [3:0] exp_hold;
    exp_first = first_set(m);
    exp_cnt   = (STOP && m != 0) ? 1 : popcount16(m);
    exp_done  = (STOP && m != 0) ? 4 * exp_first + 5 : 65;
    exp_hold  = (STOP && m != 0) ? 4'(exp_first) : 4'hF;

    pa_tt = tt; fmask = m; glitch = gl;
    @(posedge Clk); #1;
    t0 = cyc; running = 1'b1; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    chk({tag, "_busy_after_start"}, {31'd0, Busy}, 32'd1);
    chk({tag, "_done_clear"}, {30'd0, Done, Pass}, 32'd0);
    for (int i = 0; i < 200; i++) begin
      rel = int'(cyc - t0);
      if (Done) begin
        done_rel = rel;
        break;
      end
      if (rel >= 4 && rel % 4 == 0 && hv !== 4'((rel - 4) / 4)) seq_bad++;
      if (repulse && rel == 19) Start = 1'b1;
      if (rel == 20) Start = 1'b0;
      @(posedge Clk); #1;
    end
    running = 1'b0;
    chk({tag, "_done_edge"}, done_rel, exp_done);
    chk({tag, "_vec_seq"}, seq_bad, 0);
    chk({tag, "_pass"}, {31'd0, Pass}, {31'd0, m == 16'd0});
    chk({tag, "_cnt"}, {27'd0, MismatchCnt}, exp_cnt);
    chk({tag, "_fv"}, {31'd0, FailValid}, {31'd0, m != 16'd0});
    chk({tag, "_ffv"}, {28'd0, FirstFailVec}, (m != 0) ? exp_first : 0);
    chk({tag, "_hold_vec"}, {28'd0, hv}, {28'd0, exp_hold});
    chk({tag, "_busy_done"}, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk_reset_outputs("reset");
    Rst = 1'b0;
    @(posedge Clk); #1;
    chk_reset_outputs("idle_after_reset");

    run(16'($urandom), 16'h0000, 1'b0, 1'b1, "clean_repulse");
    run(16'($urandom), 16'h0040, 1'b0, 1'b0, "fail_vec6");
    run(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "all_fail");

    // Abort mid-run with an asynchronous reset between edges.
    pa_tt = 16'($urandom); fmask = 16'h0101;
    @(posedge Clk); #1;
    t0 = cyc; running = 1'b1; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    while (int'(cyc - t0) < 30) begin
      @(posedge Clk); #1;
    end
    chk("pre_abort_busy", {31'd0, Busy}, 32'd1);
    Rst = 1'b1;
    #1;
    chk_reset_outputs("abort");
    @(posedge Clk); #1;
    Rst = 1'b0; running = 1'b0;
    @(posedge Clk); #1;
    chk_reset_outputs("abort_idle");

    run(16'($urandom), 16'h0000, 1'b0, 1'b0, "after_abort");
    run(16'($urandom), 16'h0000, 1'b1, 1'b0, "glitch");
    for (int k = 0; k < 4; k++) begin
      run(16'($urandom), 16'($urandom & $urandom), 1'($urandom), 1'b0, $sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
